// File: rtl/regfile_dump_reader.sv
// Debug reader: walks a register range through a spare read port and streams
// it as a framed byte stream (A5, {idx, 4 data bytes LSB first}*, XOR checksum).
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int DATA_W   = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] first_i,
   input  logic [ADDR_W-1:0] last_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic [7:0]        byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   localparam int        LP_BYTES = DATA_W / 8;
   localparam logic [7:0] LP_HDR  = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_LOAD, S_SEND, S_CSUM, S_DONE
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_cur;
   logic [ADDR_W-1:0]   r_last;
   logic [2:0]          r_cnt;
   logic [DATA_W-1:0]   r_shift;
   logic [7:0]          r_csum;
   logic [7:0]          r_byte;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic                w_xfer;
   logic [7:0]          w_csum_nxt;

   assign w_xfer       = r_valid & byte_ready_i;
   assign w_csum_nxt   = r_csum ^ r_byte;
   assign rd_addr_o    = r_cur;
   assign byte_o       = r_byte;
   assign byte_valid_o = r_valid;
   assign busy_o       = r_busy;
   assign done_o       = r_done;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_cur   <= '0;
         r_last  <= '0;
         r_cnt   <= '0;
         r_shift <= '0;
         r_csum  <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Abort wins over any handshake in the same cycle; the pending byte is dropped.
         if (r_state != S_IDLE && abort_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_byte  <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start_i && (first_i <= last_i)) begin
                     r_state <= S_HDR;
                     r_cur   <= first_i;
                     r_last  <= last_i;
                     r_csum  <= '0;
                     r_byte  <= LP_HDR;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
               S_HDR: begin
                  if (w_xfer) begin
                     r_state <= S_LOAD;
                     r_valid <= 1'b0;
                  end
               end
               S_LOAD: begin
                  r_shift <= rd_data_i;
                  r_cnt   <= '0;
                  r_byte  <= 8'(r_cur);
                  r_valid <= 1'b1;
                  r_state <= S_SEND;
               end
               S_SEND: begin
                  if (w_xfer) begin
                     r_csum <= w_csum_nxt;
                     if (r_cnt != 3'(LP_BYTES)) begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_byte  <= r_shift[7:0];
                        r_shift <= r_shift >> 8;
                     end else if (r_cur != r_last) begin
                        // Compared before incrementing so last=31 never wraps.
                        r_cur   <= r_cur + 1'b1;
                        r_valid <= 1'b0;
                        r_state <= S_LOAD;
                     end else begin
                        r_byte  <= w_csum_nxt;
                        r_state <= S_CSUM;
                     end
                  end
               end
               S_CSUM: begin
                  if (w_xfer) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
               S_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: frames, stalls, abort, reset, ignored starts.
module tb_regfile_dump_reader;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        start_i = 1'b0;
   logic [4:0]  first_i = '0;
   logic [4:0]  last_i = '0;
   logic        abort_i = 1'b0;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_i;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i = 1'b0;
   logic        busy_o;
   logic        done_o;

   logic [31:0] regs [32];
   logic [7:0]  got [$];
   logic [7:0]  exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          dones;
   int          stall_bad;
   bit          timed_out;

   regfile_dump_reader dut (
      .CLK(CLK), .RESET(RESET), .start_i(start_i), .first_i(first_i),
      .last_i(last_i), .abort_i(abort_i), .rd_addr_o(rd_addr_o),
      .rd_data_i(rd_data_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
      .byte_ready_i(byte_ready_i), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 CLK = ~CLK;
   assign rd_data_i = regs[rd_addr_o];

   task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
      @(negedge CLK);
      first_i = f; last_i = l; start_i = 1'b1;
      @(negedge CLK);
      start_i = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0,...
   task automatic collect(input int mode);
      logic       prev_stall;
      logic [7:0] prev_byte;
      int         c;
      prev_stall = 1'b0; prev_byte = '0; c = 0;
      got.delete(); dones = 0; stall_bad = 0; timed_out = 1'b0;
      forever begin
         if (done_o) dones++;
         if (prev_stall && (!byte_valid_o || byte_o !== prev_byte)) stall_bad++;
         byte_ready_i = (mode == 0) ? 1'b1 : (c % 3 == 0);
         if (byte_valid_o && byte_ready_i) got.push_back(byte_o);
         prev_stall = byte_valid_o && !byte_ready_i;
         prev_byte  = byte_o;
         if (!busy_o) break;
         if (c == 2000) begin timed_out = 1'b1; break; end
         c++;
         @(negedge CLK);
      end
      byte_ready_i = 1'b1;
   endtask

   task automatic build_exp(input int f, input int l);
      logic [7:0] cs;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      cs = '0;
      for (int i = f; i <= l; i++) begin
         exp_q.push_back(8'(i));            cs ^= 8'(i);
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(regs[i][8*b +: 8]);
            cs ^= regs[i][8*b +: 8];
         end
      end
      exp_q.push_back(cs);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({byte_o, byte_valid_o, busy_o, done_o, rd_addr_o} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs: got byte=%h v=%b busy=%b done=%b addr=%0d, want all 0",
                  byte_o, byte_valid_o, busy_o, done_o, rd_addr_o);
      end
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic test_single_reg();
      logic [7:0] t1 [7];
      t1 = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
      regs[1] = 32'h1234_5678;
      byte_ready_i = 1'b1;
      start_dump(5'd1, 5'd1);
      checks++;
      if (byte_valid_o !== 1'b1 || byte_o !== 8'hA5) begin
         errors++;
         $display("FAIL hdr_latency: got v=%b byte=%h, want v=1 byte=a5", byte_valid_o, byte_o);
      end
      collect(0);
      checks++;
      if (timed_out || got.size() != 7) begin
         errors++;
         $display("FAIL single_len: got %0d bytes (timeout=%0d), want 7", got.size(), timed_out);
      end else begin
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (got[i] !== t1[i]) begin
               errors++;
               $display("FAIL single_byte%0d: got %h, want %h", i, got[i], t1[i]);
            end
         end
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL single_done: got %0d pulses, want 1", dones);
      end
      @(negedge CLK);
      checks++;
      if (busy_o !== 1'b0 || rd_addr_o !== 5'd1) begin
         errors++;
         $display("FAIL single_idle: got busy=%b addr=%0d, want busy=0 addr=1", busy_o, rd_addr_o);
      end
   endtask

   task automatic test_full_range();
      foreach (regs[i]) regs[i] = '0;
      start_dump(5'd0, 5'd31);
      collect(0);
      checks++;
      if (timed_out || got.size() != 162) begin
         errors++;
         $display("FAIL full_len: got %0d bytes (timeout=%0d), want 162", got.size(), timed_out);
      end else begin
         for (int k = 0; k < 32; k++) begin
            checks++;
            if (got[1 + 5*k] !== 8'(k)) begin
               errors++;
               $display("FAIL full_idx%0d: got %h, want %h", k, got[1 + 5*k], 8'(k));
            end
         end
         checks++;
         if (got[161] !== 8'h00) begin
            errors++;
            $display("FAIL full_csum: got %h, want 00", got[161]);
         end
      end
      checks++;
      if (busy_o !== 1'b0 || rd_addr_o !== 5'd31 || dones != 1) begin
         errors++;
         $display("FAIL full_end: got busy=%b addr=%0d dones=%0d, want 0/31/1", busy_o, rd_addr_o, dones);
      end
   endtask

   task automatic test_stall();
      logic [7:0] t1 [7];
      t1 = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
      regs[1] = 32'h1234_5678;
      start_dump(5'd1, 5'd1);
      collect(1);
      checks++;
      if (timed_out || got.size() != 7) begin
         errors++;
         $display("FAIL stall_len: got %0d bytes (timeout=%0d), want 7", got.size(), timed_out);
      end else begin
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (got[i] !== t1[i]) begin
               errors++;
               $display("FAIL stall_byte%0d: got %h, want %h", i, got[i], t1[i]);
            end
         end
      end
      checks++;
      if (stall_bad != 0 || dones != 1) begin
         errors++;
         $display("FAIL stall_hold: got %0d unstable stalls, %0d dones, want 0 and 1", stall_bad, dones);
      end
   endtask

   task automatic test_abort();
      int n;
      int d;
      bit hit;
      regs[0] = 32'hDEAD_BEEF; regs[1] = 32'h0102_0304;
      regs[2] = 32'hA5A5_5A5A; regs[3] = 32'h8000_0001;
      byte_ready_i = 1'b1;
      n = 0; d = 0; hit = 1'b0;
      start_dump(5'd0, 5'd3);
      for (int c = 0; c < 20; c++) begin
         if (byte_valid_o) begin
            if (n == 3) begin abort_i = 1'b1; hit = 1'b1; break; end
            n++;
         end
         @(negedge CLK);
      end
      checks++;
      if (!hit || byte_o !== 8'hBE) begin
         errors++;
         $display("FAIL abort_point: got reached=%0d byte=%h, want reached=1 byte=be", hit, byte_o);
      end
      @(negedge CLK);
      abort_i = 1'b0;
      checks++;
      if (byte_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got v=%b busy=%b, want 0 0", byte_valid_o, busy_o);
      end
      repeat (5) begin
         if (done_o) d++;
         @(negedge CLK);
      end
      checks++;
      if (d != 0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone: got dones=%0d busy=%b, want 0 0", d, busy_o);
      end
      build_exp(0, 3);
      start_dump(5'd0, 5'd3);
      collect(0);
      checks++;
      if (timed_out || got != exp_q || dones != 1) begin
         errors++;
         $display("FAIL abort_restart: got %0d bytes last=%h dones=%0d, want %0d bytes last=%h dones=1",
                  got.size(), got.size() > 0 ? got[$] : 8'h00, dones, exp_q.size(), exp_q[$]);
      end
   endtask

   task automatic test_reset_midframe();
      regs[2] = 32'hCAFE_F00D;
      byte_ready_i = 1'b1;
      start_dump(5'd2, 5'd3);
      repeat (3) @(negedge CLK);
      checks++;
      if (busy_o !== 1'b1 || rd_addr_o !== 5'd2) begin
         errors++;
         $display("FAIL rst_pre: got busy=%b addr=%0d, want 1 2", busy_o, rd_addr_o);
      end
      #2 RESET = 1'b1;
      #1;
      checks++;
      if ({byte_o, byte_valid_o, busy_o, done_o, rd_addr_o} !== 17'd0) begin
         errors++;
         $display("FAIL rst_async: got byte=%h v=%b busy=%b done=%b addr=%0d, want all 0",
                  byte_o, byte_valid_o, busy_o, done_o, rd_addr_o);
      end
      @(negedge CLK);
      RESET = 1'b0;
      repeat (5) @(negedge CLK);
      checks++;
      if (busy_o !== 1'b0 || byte_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_after: got busy=%b v=%b, want 0 0", busy_o, byte_valid_o);
      end
   endtask

   task automatic test_ignored_start();
      bit act;
      act = 1'b0;
      start_dump(5'd5, 5'd3);
      repeat (5) begin
         if (busy_o || byte_valid_o) act = 1'b1;
         @(negedge CLK);
      end
      checks++;
      if (act || rd_addr_o !== 5'd0) begin
         errors++;
         $display("FAIL bad_range: got activity=%0d addr=%0d, want 0 0", act, rd_addr_o);
      end
      regs[1] = 32'h1111_2222; regs[2] = 32'h3333_4444;
      build_exp(1, 2);
      start_dump(5'd1, 5'd2);
      fork
         collect(0);
         begin
            repeat (3) @(negedge CLK);
            first_i = 5'd0; last_i = 5'd31; start_i = 1'b1;
            @(negedge CLK);
            start_i = 1'b0;
         end
      join
      checks++;
      if (timed_out || got != exp_q) begin
         errors++;
         $display("FAIL busy_start_frame: got %0d bytes, want %0d bytes of range 1..2",
                  got.size(), exp_q.size());
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (busy_o !== 1'b0 || byte_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_queued: got busy=%b v=%b, want 0 0", busy_o, byte_valid_o);
      end
   endtask

   initial begin
      foreach (regs[i]) regs[i] = '0;
      test_reset();
      test_single_reg();
      test_full_range();
      test_stall();
      test_abort();
      test_reset_midframe();
      test_ignored_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
